mem_access_ctrl: RTL and testbench

Load/store initiator for the MEM stage of the pipelined MIPS32 core. Accepts one load or store request from the pipeline, drives the byte-lane data-memory bus (chip enable, write enable, word address, byte selects, write data) for a configurable number of cycles, then returns sign- or zero-extended load data and releases the pipeline stall. It sits between the MEM stage and the data memory, on the opposite side of the bus from the memory.

---
 rtl/mem_access_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store initiator for a big-endian byte-lane bus.
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses.
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        ready_o,
    output logic [31:0] rdata_o,
    output logic        excp_o,
    output logic        mem_ce_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        excp_q;

    logic        misaligned;
    logic        sz_byte, sz_half, is_store, sgn;
    logic        last;
    logic [3:0]  sel;
    logic [31:0] wlanes;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;

`ifdef MEM_ALIGN_CHECK_EN
    // Halfwords need addr[0]=0, words need addr[1:0]=00
    always_comb begin
        misaligned = 1'b0;
        case (op_i)
            3'b010, 3'b011, 3'b110: misaligned = addr_i[0];
            3'b100, 3'b111:         misaligned = |addr_i[1:0];
            default:                misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    // Decode the latched opcode into size, direction and signedness
    always_comb begin
        sz_byte  = 1'b0;
        sz_half  = 1'b0;
        is_store = 1'b0;
        sgn      = 1'b0;
        case (op_q)
            3'b000: begin sz_byte = 1'b1; sgn = 1'b1; end
            3'b001: sz_byte = 1'b1;
            3'b010: begin sz_half = 1'b1; sgn = 1'b1; end
            3'b011: sz_half = 1'b1;
            3'b100: sgn = 1'b0;
            3'b101: begin sz_byte = 1'b1; is_store = 1'b1; end
            3'b110: begin sz_half = 1'b1; is_store = 1'b1; end
            default: is_store = 1'b1;
        endcase
    end

    // Big-endian lane selection, write replication and load extension
    always_comb begin
        if (sz_byte) begin
            sel = 4'b1000 >> addr_q[1:0];
        end else if (sz_half) begin
            sel = addr_q[1] ? 4'b0011 : 4'b1100;
        end else begin
            sel = 4'b1111;
        end
        if (sz_byte) begin
            wlanes = {4{wdata_q[7:0]}};
        end else if (sz_half) begin
            wlanes = {2{wdata_q[15:0]}};
        end else begin
            wlanes = wdata_q;
        end
        case (addr_q[1:0])
            2'b00:   lane_b = mem_data_i[31:24];
            2'b01:   lane_b = mem_data_i[23:16];
            2'b10:   lane_b = mem_data_i[15:8];
            default: lane_b = mem_data_i[7:0];
        endcase
        lane_h = addr_q[1] ? mem_data_i[15:0] : mem_data_i[31:16];
        if (sz_byte) begin
            load_val = {{24{sgn & lane_b[7]}}, lane_b};
        end else if (sz_half) begin
            load_val = {{16{sgn & lane_h[15]}}, lane_h};
        end else begin
            load_val = mem_data_i;
        end
    end

    assign last = (cnt == 4'd1);

    // Next-state logic and bus/handshake outputs
    always_comb begin
        state_nxt  = state;
        stall_o    = 1'b0;
        ready_o    = 1'b0;
        mem_ce_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = 32'd0;
        mem_sel_o  = 4'd0;
        mem_data_o = 32'd0;
        case (state)
            IDLE: begin
                stall_o = req_i & rst;
                if (req_i) begin
                    state_nxt = misaligned ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                stall_o    = 1'b1;
                mem_ce_o   = 1'b1;
                mem_we_o   = is_store;
                mem_addr_o = {addr_q[31:2], 2'b00};
                mem_sel_o  = sel;
                mem_data_o = wlanes;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ready_o   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, wait counter, request latch and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            op_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            excp_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_i) begin
                op_q    <= op_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                rdata_q <= 32'd0;
                excp_q  <= misaligned;
                cnt     <= misaligned ? 4'd0 : 4'(WAIT_CYCLES);
            end else if (state == ACCESS) begin
                cnt <= cnt - 4'd1;
                if (last) begin
                    rdata_q <= is_store ? 32'd0 : load_val;
                end
            end
        end
    end

    assign rdata_o = rdata_q;
    assign excp_o  = excp_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and random load/store traffic against a
// byte-array reference model of a big-endian data memory.
module tb_mem_access_ctrl;

    localparam int W = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        stall, ready, excp;
    logic [31:0] rdata;
    logic        mem_ce, mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic [3:0]  mem_sel;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] last_rd = 32'd0;
    logic        last_ex = 1'b0;

    logic [31:0] mem [16] = '{default: 32'd0};
    logic [31:0] ref_mem [16] = '{default: 32'd0};

    mem_access_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .op_i       (op),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .stall_o    (stall),
        .ready_o    (ready),
        .rdata_o    (rdata),
        .excp_o     (excp),
        .mem_ce_o   (mem_ce),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_sel_o  (mem_sel),
        .mem_data_o (mem_wd),
        .mem_data_i (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (mem_ce && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_sel[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wd[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int sz(input logic [2:0] o);
        if (o == 3'd0 || o == 3'd1 || o == 3'd5) return 1;
        if (o == 3'd2 || o == 3'd3 || o == 3'd6) return 2;
        return 4;
    endfunction

    function automatic bit misal(input logic [2:0] o, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return (int'(a[1:0]) % sz(o)) != 0;
`else
        return (o == 3'd7) && (a == 32'hFFFF_FFFF);
`endif
    endfunction

    task automatic rand_inputs();
        req   = 1'($urandom);
        op    = 3'($urandom);
        addr  = $urandom;
        wdata = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req = 1'b0;
            #1;
            check("idle_stall", 32'(stall), 0);
            check("idle_ce", 32'(mem_ce), 0);
            check("idle_ready", 32'(ready), 0);
            check("hold_rdata", rdata, last_rd);
            check("hold_excp", 32'(excp), 32'(last_ex));
        end
    endtask

    task automatic xact(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] w);
        int          n, first, idx;
        bit          st, mis;
        logic [3:0]  esel;
        logic [31:0] edat, erd;
        n     = sz(o);
        st    = (o >= 3'd5);
        mis   = misal(o, a);
        idx   = int'(a[5:2]);
        first = int'(a[1:0]) - (int'(a[1:0]) % n);
        esel  = 4'd0;
        erd   = 32'd0;
        for (int k = first; k < first + n; k++) esel[3-k] = 1'b1;
        for (int p = 0; p < 4; p++) edat[8*p +: 8] = w[8*(p % n) +: 8];
        if (!mis) begin
            if (st) begin
                for (int k = first; k < first + n; k++)
                    ref_mem[idx][8*(3-k) +: 8] = edat[8*(3-k) +: 8];
            end else begin
                for (int k = first; k < first + n; k++)
                    erd = (erd << 8) | 32'(ref_mem[idx][8*(3-k) +: 8]);
                if (o == 3'd0 && erd[7]) erd = erd | 32'hFFFF_FF00;
                if (o == 3'd2 && erd[15]) erd = erd | 32'hFFFF_0000;
            end
        end
        @(negedge clk);
        req = 1'b1; op = o; addr = a; wdata = w;
        #1;
        check("req_stall", 32'(stall), 1);
        check("req_ready", 32'(ready), 0);
        if (!mis) begin
            for (int c = 0; c < W; c++) begin
                @(negedge clk);
                rand_inputs();
                #1;
                check("acc_ce", 32'(mem_ce), 1);
                check("acc_we", 32'(mem_we), 32'(st));
                check("acc_addr", mem_addr, {a[31:2], 2'b00});
                check("acc_sel", 32'(mem_sel), 32'(esel));
                if (st) check("acc_wdata", mem_wd, edat);
                check("acc_stall", 32'(stall), 1);
                check("acc_ready", 32'(ready), 0);
            end
        end
        @(negedge clk);
        rand_inputs();
        #1;
        check("done_ready", 32'(ready), 1);
        check("done_stall", 32'(stall), 0);
        check("done_ce", 32'(mem_ce), 0);
        check("done_we", 32'(mem_we), 0);
        check("done_sel", 32'(mem_sel), 0);
        check("done_addr", mem_addr, 0);
        check("done_rdata", rdata, erd);
        check("done_excp", 32'(excp), 32'(mis));
        last_rd = erd;
        last_ex = mis;
    endtask

    initial begin
        #1;
        check("rst_stall", 32'(stall), 0);
        check("rst_ready", 32'(ready), 0);
        check("rst_ce", 32'(mem_ce), 0);
        check("rst_rdata", rdata, 0);
        check("rst_excp", 32'(excp), 0);
        #20;
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        xact(3'd7, 32'h10, 32'hDEAD_BEEF);
        xact(3'd5, 32'h13, 32'h0000_00A5);
        xact(3'd0, 32'h13, 32'h0);
        xact(3'd1, 32'h13, 32'h0);
        idle(1);
        xact(3'd7, 32'h10, 32'h1234_8001);
        xact(3'd2, 32'h12, 32'h0);
        xact(3'd3, 32'h10, 32'h0);
        xact(3'd7, 32'h20, 32'hCAFE_F00D);
        xact(3'd4, 32'h20, 32'h0);
        xact(3'd4, 32'h20, 32'h0);
        xact(3'd4, 32'h22, 32'h0);
        idle(1);

        // abort a store while the bus is active
        @(negedge clk);
        req = 1'b1; op = 3'd7; addr = 32'h30; wdata = 32'h5555_AAAA;
        @(negedge clk);
        #1;
        check("abort_ce_before", 32'(mem_ce), 1);
        rst = 1'b0;
        #1;
        check("abort_ce", 32'(mem_ce), 0);
        check("abort_we", 32'(mem_we), 0);
        check("abort_sel", 32'(mem_sel), 0);
        check("abort_addr", mem_addr, 0);
        check("abort_data", mem_wd, 0);
        check("abort_stall", 32'(stall), 0);
        check("abort_ready", 32'(ready), 0);
        last_rd = 32'd0;
        last_ex = 1'b0;
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        idle(2);
        xact(3'd4, 32'h30, 32'h0);

        for (int t = 0; t < 80; t++) begin
            xact(3'($urandom), {26'd0, 6'($urandom)}, $urandom);
            idle(int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
